// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes,
// ALU operation encodings and the sequencer state type.
package multicycle_control_unit_pkg;

   // Major opcodes handled by the R/I/L/S datapath
   localparam logic [6:0] OP_TYPE_R = 7'b0110011;
   localparam logic [6:0] OP_TYPE_I = 7'b0010011;
   localparam logic [6:0] OP_TYPE_L = 7'b0000011;
   localparam logic [6:0] OP_TYPE_S = 7'b0100011;

   // ALU operation encodings, {funct7[5], funct3} style
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   // funct3 values of the shift instructions
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRX = 3'b101;

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEMORY    = 3'd3,
      WRITEBACK = 3'd4,
      HALT      = 3'd5
   } state_t;

   // True for the opcodes this core can sequence
   function automatic logic is_supported(input logic [6:0] opcode);
      return (opcode == OP_TYPE_R) || (opcode == OP_TYPE_I) ||
             (opcode == OP_TYPE_L) || (opcode == OP_TYPE_S);
   endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Memory handshakes and datapath control bundle between the control unit
// (master) and the datapath / instruction and data memories (slave).
interface multicycle_control_unit_if;

   logic [31:0] instrCode;
   logic        instrReady;
   logic        dataReady;
   logic        instrReq;
   logic        irWe;
   logic        pcEn;
   logic        regFileWe;
   logic [3:0]  aluControl;
   logic        aluSrcMuxSel;
   logic        RFWDSrcMuxSel;
   logic        shamt_signal;
   logic        dataReq;
   logic        dataWe;
   logic        retire;
   logic        illegal;

   modport master (
      input  instrCode, instrReady, dataReady,
      output instrReq, irWe, pcEn, regFileWe, aluControl, aluSrcMuxSel,
             RFWDSrcMuxSel, shamt_signal, dataReq, dataWe, retire, illegal
   );

   modport slave (
      output instrCode, instrReady, dataReady,
      input  instrReq, irWe, pcEn, regFileWe, aluControl, aluSrcMuxSel,
             RFWDSrcMuxSel, shamt_signal, dataReq, dataWe, retire, illegal
   );

endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU decode: opcode/funct fields to ALU operation, operand-B
// select and shift-amount immediate select.
module alu_decoder
   import multicycle_control_unit_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7_b5_i,
   output logic [3:0] alu_control_o,
   output logic       alu_src_o,
   output logic       shamt_o
);

   // Decode ALU operation; loads and stores compute an address with ADD
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      alu_control_o = ALU_ADD;
      alu_src_o     = 1'b0;
      shamt_o       = 1'b0;
      unique case (opcode_i)
         OP_TYPE_R: begin
            alu_control_o = {funct7_b5_i, funct3_i};
         end
         OP_TYPE_I: begin
            // instr[30] is an immediate bit except for SRLI/SRAI
            alu_control_o = {(funct3_i == F3_SRX) & funct7_b5_i, funct3_i};
            alu_src_o     = 1'b1;
            shamt_o       = (funct3_i == F3_SLL) || (funct3_i == F3_SRX);
         end
         OP_TYPE_L, OP_TYPE_S: begin
            alu_src_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the RV32I R/I/L/S datapath with ready/req
// handshakes on instruction and data memory.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
(
   input  logic                              clk,
   input  logic                              reset,
   multicycle_control_unit_if.master         bus
);

   state_t     state_q, state_d;
   logic       run_q;
   logic [6:0] opcode;
   logic       is_mem, is_store, ctl_active;
   logic [3:0] dec_alu;
   logic       dec_src, dec_shamt;
   logic       unused_instr_bits;

   assign opcode   = bus.instrCode[6:0];
   assign is_store = (opcode == OP_TYPE_S);
   assign is_mem   = (opcode == OP_TYPE_L) || is_store;
   assign unused_instr_bits = ^{bus.instrCode[31], bus.instrCode[29:15],
                                bus.instrCode[11:7]};

   alu_decoder u_alu_decoder (
      .opcode_i      (opcode),
      .funct3_i      (bus.instrCode[14:12]),
      .funct7_b5_i   (bus.instrCode[30]),
      .alu_control_o (dec_alu),
      .alu_src_o     (dec_src),
      .shamt_o       (dec_shamt)
   );

   // State register; run_q keeps every output low until the first edge after reset release
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (!reset) begin
         state_q <= FETCH;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   // Next-state and handshake/enable outputs
   always_comb begin
      state_d           = state_q;
      bus.instrReq      = 1'b0;
      bus.irWe          = 1'b0;
      bus.pcEn          = 1'b0;
      bus.regFileWe     = 1'b0;
      bus.RFWDSrcMuxSel = 1'b0;
      bus.dataReq       = 1'b0;
      bus.dataWe        = 1'b0;
      bus.retire        = 1'b0;
      bus.illegal       = 1'b0;
      if (run_q) begin
         unique case (state_q)
            FETCH: begin
               bus.instrReq = 1'b1;
               if (bus.instrReady) begin
                  bus.irWe = 1'b1;
                  state_d  = DECODE;
               end
            end
            DECODE: begin
               state_d = is_supported(opcode) ? EXECUTE : HALT;
            end
            EXECUTE: begin
               if (is_mem) begin
                  state_d = MEMORY;
               end else begin
                  bus.regFileWe = 1'b1;
                  bus.pcEn      = 1'b1;
                  bus.retire    = 1'b1;
                  state_d       = FETCH;
               end
            end
            MEMORY: begin
               bus.dataReq = 1'b1;
               bus.dataWe  = is_store;
               if (bus.dataReady) begin
                  if (is_store) begin
                     bus.pcEn   = 1'b1;
                     bus.retire = 1'b1;
                     state_d    = FETCH;
                  end else begin
                     state_d = WRITEBACK;
                  end
               end
            end
            WRITEBACK: begin
               bus.regFileWe     = 1'b1;
               bus.RFWDSrcMuxSel = 1'b1;
               bus.pcEn          = 1'b1;
               bus.retire        = 1'b1;
               state_d           = FETCH;
            end
            HALT: begin
               bus.illegal = 1'b1;
            end
            default: state_d = FETCH;
         endcase
      end
   end

   // Datapath controls are only driven while an instruction is executing
   assign ctl_active = run_q && ((state_q == EXECUTE) || (state_q == MEMORY) ||
                                 (state_q == WRITEBACK));
   assign bus.aluControl   = ctl_active ? dec_alu : 4'b0000;
   assign bus.aluSrcMuxSel = ctl_active & dec_src;
   assign bus.shamt_signal = ctl_active & dec_shamt;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: a responder models the
// memories' ready lines, a monitor collects per-instruction behaviour and
// compares it against expectations queued when each instruction is issued.
module tb_multicycle_control_unit;

   typedef struct {
      string      name;
      logic [3:0] alu;
      logic       src;
      logic       shamt;
      logic       rfwd;
      logic       dwe;
      int         cyc;
      int         rfwe;
      int         dreq;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   multicycle_control_unit_if bus ();

   multicycle_control_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   int   iw_left = 0;
   int   dw_left = 0;
   logic spur = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Memory responder: ready after the requested number of wait cycles
   initial begin
      bus.instrReady = 1'b0;
      bus.dataReady  = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!reset) begin
            bus.instrReady = 1'b0;
            bus.dataReady  = 1'b0;
         end else begin
            if (bus.instrReq) begin
               if (iw_left > 0) begin bus.instrReady = 1'b0; iw_left--; end
               else bus.instrReady = 1'b1;
            end else bus.instrReady = spur;
            if (bus.dataReq) begin
               if (dw_left > 0) begin bus.dataReady = 1'b0; dw_left--; end
               else bus.dataReady = 1'b1;
            end else bus.dataReady = spur;
         end
      end
   end

   // Monitor: per-instruction observation, compared on retire
   logic       armed = 1'b0;
   int         cyc = 0, exec_at = -10, irwe_n = 0, pcen_n = 0, rfwe_n = 0, dreq_n = 0;
   logic [3:0] cap_alu = 0;
   logic       cap_src = 0, cap_shamt = 0, rfwd_last = 0, dwe_or = 0, dwe_and = 1;
   logic [5:0] dec_ctl = 0;

   task automatic clear_mon();
      cyc = 0; exec_at = -10; irwe_n = 0; pcen_n = 0; rfwe_n = 0; dreq_n = 0;
      cap_alu = 0; cap_src = 0; cap_shamt = 0; rfwd_last = 0;
      dwe_or = 0; dwe_and = 1; dec_ctl = 0;
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         armed = 1'b0;
         clear_mon();
      end else begin
         if (!armed && bus.instrReq) armed = 1'b1;
         if (armed) begin
            cyc++;
            if (bus.irWe) begin irwe_n++; exec_at = cyc + 2; end
            if (cyc == exec_at - 1)
               dec_ctl = {bus.aluControl, bus.aluSrcMuxSel, bus.shamt_signal};
            if (cyc == exec_at) begin
               cap_alu = bus.aluControl; cap_src = bus.aluSrcMuxSel; cap_shamt = bus.shamt_signal;
            end
            if (bus.pcEn) pcen_n++;
            if (bus.regFileWe) begin rfwe_n++; rfwd_last = bus.RFWDSrcMuxSel; end
            if (bus.dataReq) begin dreq_n++; dwe_or |= bus.dataWe; dwe_and &= bus.dataWe; end
            if (bus.retire) begin
               if (exp_q.size() == 0) check("unexpected_retire", 1, 0);
               else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check({e.name, ".cycles"}, cyc, e.cyc);
                  check({e.name, ".aluControl"}, cap_alu, e.alu);
                  check({e.name, ".aluSrcMuxSel"}, cap_src, e.src);
                  check({e.name, ".shamt_signal"}, cap_shamt, e.shamt);
                  check({e.name, ".decode_ctl_zero"}, dec_ctl, 0);
                  check({e.name, ".regFileWe_cycles"}, rfwe_n, e.rfwe);
                  check({e.name, ".RFWDSrcMuxSel"}, rfwd_last, e.rfwd);
                  check({e.name, ".dataReq_cycles"}, dreq_n, e.dreq);
                  check({e.name, ".dataWe_any"}, dwe_or, e.dwe);
                  if (e.dwe) check({e.name, ".dataWe_held"}, dwe_and, 1);
                  check({e.name, ".irWe_pulses"}, irwe_n, 1);
                  check({e.name, ".pcEn_pulses"}, pcen_n, 1);
               end
               clear_mon();
            end
         end
      end
   end

   task automatic issue(input string name, input logic [31:0] code, input int iw, input int dw,
                        input logic [3:0] alu, input logic src, input logic shamt,
                        input logic rfwd, input logic dwe, input int cycles,
                        input int rfwe, input int dreq);
      exp_t e;
      e.name = name; e.alu = alu; e.src = src; e.shamt = shamt; e.rfwd = rfwd;
      e.dwe = dwe; e.cyc = cycles; e.rfwe = rfwe; e.dreq = dreq;
      exp_q.push_back(e);
      bus.instrCode = code;
      iw_left = iw;
      dw_left = dw;
   endtask

   // Wait until the monitor has consumed all expectations, then align to FETCH
   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   n;
      logic seen;
      bus.instrCode = 32'h0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_instrReq", bus.instrReq, 0);
      check("rst_illegal", bus.illegal, 0);
      check("rst_outputs", {bus.irWe, bus.pcEn, bus.regFileWe, bus.aluControl, bus.aluSrcMuxSel,
                            bus.RFWDSrcMuxSel, bus.shamt_signal, bus.dataReq, bus.dataWe,
                            bus.retire}, 0);

      @(posedge clk); #1;
      issue("add0", 32'h002081B3, 0, 0, 4'b0000, 0, 0, 0, 0, 3, 1, 0);
      reset = 1'b1;
      @(negedge clk); check("release_no_req", bus.instrReq, 0);
      @(negedge clk); check("release_req", bus.instrReq, 1);
      drain();
      issue("add1", 32'h002081B3, 0, 0, 4'b0000, 0, 0, 0, 0, 3, 1, 0); drain();
      issue("add2", 32'h002081B3, 0, 0, 4'b0000, 0, 0, 0, 0, 3, 1, 0); drain();
      issue("sra",  32'h4020D3B3, 0, 0, 4'b1101, 0, 0, 0, 0, 3, 1, 0); drain();
      issue("slli", 32'h00309313, 0, 0, 4'b0001, 1, 1, 0, 0, 3, 1, 0); drain();
      issue("srli", 32'h0030D313, 0, 0, 4'b0101, 1, 1, 0, 0, 3, 1, 0); drain();
      issue("srai", 32'h4030D313, 0, 0, 4'b1101, 1, 1, 0, 0, 3, 1, 0); drain();
      issue("addi_b30", 32'h40008293, 0, 0, 4'b0000, 1, 0, 0, 0, 3, 1, 0); drain();
      issue("sub",  32'h402081B3, 0, 0, 4'b1000, 0, 0, 0, 0, 3, 1, 0); drain();
      issue("lw_w3", 32'h0080A203, 0, 3, 4'b0000, 1, 0, 1, 0, 8, 1, 4); drain();
      issue("sw_w2", 32'h0020A223, 0, 2, 4'b0000, 1, 0, 0, 1, 6, 0, 3); drain();
      issue("add_iw2", 32'h002081B3, 2, 0, 4'b0000, 0, 0, 0, 0, 5, 1, 0); drain();
      spur = 1'b1;
      issue("add_spur", 32'h002081B3, 0, 0, 4'b0000, 0, 0, 0, 0, 3, 1, 0); drain();
      issue("sw_spur", 32'h0020A223, 0, 0, 4'b0000, 1, 0, 0, 1, 4, 0, 1); drain();
      spur = 1'b0;
      issue("lw_w0", 32'h0080A203, 0, 0, 4'b0000, 1, 0, 1, 0, 5, 1, 1); drain();

      // Unsupported opcode: halt, sticky illegal, bus quiet
      bus.instrCode = 32'hFFFFFFFF;
      n = 0;
      while (bus.illegal !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      check("halt_illegal", bus.illegal, 1);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen |= bus.pcEn | bus.instrReq | bus.dataReq | bus.regFileWe | bus.irWe | bus.retire;
      end
      check("halt_quiet", seen, 0);
      check("halt_sticky", bus.illegal, 1);
      check("halt_ctl_zero", {bus.aluControl, bus.aluSrcMuxSel, bus.shamt_signal}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("halt_reset_clears", bus.illegal, 0);
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of a load's data-memory wait
      bus.instrCode = 32'h0080A203;
      iw_left = 0;
      dw_left = 10;
      reset = 1'b1;
      n = 0;
      while (bus.dataReq !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      check("midrst_req_seen", bus.dataReq, 1);
      repeat (2) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_dataReq_drop", bus.dataReq, 0);
      check("midrst_instrReq", bus.instrReq, 0);
      seen = bus.regFileWe;
      dw_left = 0;
      repeat (2) begin @(negedge clk); seen |= bus.regFileWe | bus.retire | bus.dataReq; end
      check("midrst_no_writeback", seen, 0);
      @(posedge clk); #1;
      issue("add_after_rst", 32'h002081B3, 0, 0, 4'b0000, 0, 0, 0, 0, 3, 1, 0);
      reset = 1'b1;
      @(negedge clk); check("midrst_release_no_req", bus.instrReq, 0);
      @(negedge clk); check("midrst_release_req", bus.instrReq, 1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
      $fatal(1);
   end

endmodule
